game_timer_bank: RTL

- Parametrised bank of NUM_CH independent up-counting timers, the successor to the single-channel two-second counter in the BlackJack datapath.
- Each channel has its own terminal value, one-shot or periodic mode, hold (pause) and clear.
- Each channel raises a one-cycle tick and, in one-shot mode, a sticky done flag.
- Used by the game FSM for dealer-reveal delays, player decision timeouts and display blink periods, all from the 2 kHz clock.

---
 rtl/game_timer_bank.sv | 120 ++++++++++++
 1 files changed

// File: rtl/game_timer_bank.sv
// Bank of NUM_CH independent up-counting timers clocked from the 2 kHz game clock.
// Each channel runs one-shot or periodic to a latched terminal value, with hold and clear.
`timescale 1ns/1ps

module game_timer_bank #(
  parameter int WIDTH  = 12,
  parameter int NUM_CH = 4
) (
  input  logic                    clk_2K,
  input  logic                    i_Reset,
  input  logic [NUM_CH-1:0]       i_Start,
  input  logic [NUM_CH-1:0]       i_Clear,
  input  logic [NUM_CH-1:0]       i_Hold,
  input  logic [NUM_CH-1:0]       i_Periodic,
  input  logic [NUM_CH*WIDTH-1:0] i_Limit,
  output logic [NUM_CH*WIDTH-1:0] o_Count,
  output logic [NUM_CH-1:0]       o_Tick,
  output logic [NUM_CH-1:0]       o_Done,
  output logic [NUM_CH-1:0]       o_Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q    [NUM_CH];
  state_e           state_d    [NUM_CH];
  logic [WIDTH-1:0] count_q    [NUM_CH];
  logic [WIDTH-1:0] count_d    [NUM_CH];
  logic [WIDTH-1:0] limit_q    [NUM_CH];
  logic [WIDTH-1:0] limit_d    [NUM_CH];
  logic [NUM_CH-1:0] periodic_q, periodic_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  // A channel advances only when running, unheld and not overridden by clear/start.
  logic [NUM_CH-1:0] advance;
  logic [NUM_CH-1:0] at_limit;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      at_limit[k] = (count_q[k] == limit_q[k]);
      advance[k]  = (state_q[k] == RUN) && !i_Hold[k] && !i_Clear[k] && !i_Start[k];
    end
  end

  // State register. The latched limits and modes are reset too, so a fresh bank reads all zero.
  always_ff @(posedge clk_2K or posedge i_Reset) begin
    if (i_Reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= IDLE;
        count_q[k] <= '0;
        limit_q[k] <= '0;
      end
      periodic_q <= '0;
      tick_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its peers.
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        count_q[k] <= count_d[k];
        limit_q[k] <= limit_d[k];
      end
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
    end
  end

  // Next-state logic: clear beats start, start beats the terminal event.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      // NOTE: default every comb output first; a missing branch would otherwise infer a latch.
      state_d[k] = state_q[k];
      if (i_Clear[k]) begin
        state_d[k] = IDLE;
      end else if (i_Start[k]) begin
        state_d[k] = RUN;
      end else if (advance[k] && at_limit[k] && !periodic_q[k]) begin
        state_d[k] = DONE;
      end
    end
  end

  // Datapath: count, latched limit/mode and the registered terminal tick.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      count_d[k]    = count_q[k];
      limit_d[k]    = limit_q[k];
      periodic_d[k] = periodic_q[k];
      tick_d[k]     = 1'b0;
      if (i_Clear[k]) begin
        count_d[k] = '0;
      end else if (i_Start[k]) begin
        count_d[k]    = '0;
        limit_d[k]    = i_Limit[k*WIDTH +: WIDTH];
        periodic_d[k] = i_Periodic[k];
      end else if (advance[k]) begin
        if (at_limit[k]) begin
          tick_d[k] = 1'b1;
          // One-shot holds at the limit; periodic wraps back to zero.
          if (periodic_q[k]) count_d[k] = '0;
        end else begin
          count_d[k] = count_q[k] + WIDTH'(1);
        end
      end
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      o_Count[k*WIDTH +: WIDTH] = count_q[k];
      o_Busy[k]                 = (state_q[k] == RUN);
      o_Done[k]                 = (state_q[k] == DONE);
    end
    o_Tick = tick_q;
  end

endmodule
